// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: streams N-bit slices of a W-bit operand pair through an external adder.
// Optional subtract mode is enabled with `define MP_ADD_SUB_EN (adds the in_sub port).
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high
//   RUN   | one slice per cycle through the adder, LSB first
//   DONE  | result held on out_sum/out_cout until out_ready
module mp_add_seq #(
    parameter  int N  = 4,
    parameter  int K  = 4,
    localparam int W  = N * K,
    localparam int CW = (K > 1) ? $clog2(K) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
`ifdef MP_ADD_SUB_EN
    input  logic         in_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a_reg, b_reg, sum_reg;
    logic          cin_reg, carry_reg;
    logic [CW-1:0] cnt;
    logic          last;
    logic [N-1:0]  b_slice;
    logic          cin0;
`ifdef MP_ADD_SUB_EN
    logic          sub_reg;
`endif

    assign last    = (cnt == CW'(K - 1));
    assign b_slice = b_reg[int'(cnt)*N +: N];

`ifdef MP_ADD_SUB_EN
    // Two's-complement subtract: invert B and inject a 1 at slice 0.
    assign cin0 = sub_reg | cin_reg;
`else
    assign cin0 = cin_reg;
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy    = 1'b1;
                add_a   = a_reg[int'(cnt)*N +: N];
`ifdef MP_ADD_SUB_EN
                add_b   = sub_reg ? ~b_slice : b_slice;
`else
                add_b   = b_slice;
`endif
                add_cin = (cnt == '0) ? cin0 : carry_reg;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_sum   = sum_reg;
                out_cout  = carry_reg;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
`ifdef MP_ADD_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= in_a;
                        b_reg   <= in_b;
                        cin_reg <= in_cin;
                        cnt     <= '0;
                        sum_reg <= '0;
`ifdef MP_ADD_SUB_EN
                        sub_reg <= in_sub;
`endif
                    end
                end
                RUN: begin
                    sum_reg[int'(cnt)*N +: N] <= add_sum;
                    carry_reg                 <= add_cout;
                    if (!last) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
- Multi-precision add sequencer in front of the team's N-bit parallel-prefix adder.
- Accepts one W-bit operand pair (W = N*K) over a valid/ready handshake.
- Feeds the external combinational adder one N-bit slice per cycle, LSB slice first, chaining the adder's carry-out into the next slice's carry-in.
- Collects the slice sums into a W-bit result and presents it on an output valid/ready handshake.

Parameters:
- N, 4, slice width; must equal the width of the attached adder; N >= 1.
- K, 4, number of slices per operand; K >= 1.
- W (localparam), N*K, full operand width.
- CW (localparam), max(1, $clog2(K)), slice counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_cin  in  1  carry-in for slice 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  full sum.
- out_cout  out  1  carry-out of slice K-1.
- add_a  out  N  slice of A to adder.
- add_b  out  N  slice of B to adder.
- add_cin  out  1  carry-in to adder.
- add_sum  in  N  adder sum (combinational return, same cycle).
- add_cout  in  1  adder carry-out (same cycle).
- busy  out  1  high in RUN or DONE.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0, add_a=0, add_b=0, add_cin=0, counter=0, carry register=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge:
    - latch in_a, in_b, in_cin;
    - clear counter and sum register;
    - go to RUN.
  - RUN: drive add_a=a_reg[cnt*N +: N], add_b=b_reg[cnt*N +: N], add_cin=(cnt==0)?cin_reg:carry_reg.
    - Each edge: sum_reg[cnt*N +: N]<=add_sum; carry_reg<=add_cout.
    - If cnt==K-1, go to DONE; otherwise cnt<=cnt+1.
  - DONE: out_valid=1, out_sum=sum_reg, out_cout=carry_reg. Values are stable while out_ready=0. On out_ready, go to IDLE.
- Outside RUN: add_a, add_b and add_cin are driven to 0.
- Latency: accept edge e0 → out_valid high after edge e0+K. Throughput is one transaction per K+2 cycles.
- No input/output overlap: in_ready=0 during RUN and DONE. in_valid in those states is ignored; upstream must hold its data.
- K=1: a single RUN cycle. The counter is never incremented.
- Wrap-around: modulo-2^W sum. The carry out of the top slice appears only on out_cout.
- The attached adder must be purely combinational; its path is add_a → add_sum within one cycle.
- Reset mid-RUN or mid-DONE aborts the transaction with no output. All registers return to reset values on the next edge.
- out_ready held high in IDLE or RUN has no effect.

Optional Feature:
- Macro: MP_ADD_SUB_EN.
- Defined:
  - Extra port in_sub (in, 1) is latched at accept.
  - When in_sub=1: add_b is the bitwise inverse of the B slice, and slice-0 add_cin is forced to 1 (in_cin ignored). The result is A−B mod 2^W.
  - out_cout=1 means no borrow (A>=B unsigned).
- Not defined:
  - The in_sub port does not exist.
  - The block performs addition only.

Test Plan (N=4, K=4, W=16):
- Carry chain: a=0xFFFF, b=0x0001, cin=0 → out_sum=0x0000, out_cout=1. out_valid rises exactly 4 edges after accept. add_cin is 0,1,1,1 across the RUN cycles.
- Carry-in: a=0x1234, b=0x4321, cin=1 → out_sum=0x5556, out_cout=0. add_a shows 0x4,0x3,0x2,0x1 in order.
- Backpressure: a=0x8000, b=0x8000, out_ready=0 for 3 cycles after out_valid → out_sum=0x0000 and out_cout=1 held stable. in_ready=0 throughout. A new in_valid pulse during DONE is not accepted.
- Reset mid-op: assert rst in the 2nd RUN cycle → next cycle state=IDLE, in_ready=1, out_valid=0, out_sum=0. No result is ever produced.
- Back-to-back: two queued transactions (0x0001+0x0001, then 0x00FF+0x0001) with out_ready=1 → results 0x0002 then 0x0100. Second accept occurs exactly 1 cycle after the first result handshake.
- MP_ADD_SUB_EN: a=0x0005, b=0x0007, in_sub=1 → out_sum=0xFFFE, out_cout=0. a=0x0007, b=0x0005 → out_sum=0x0002, out_cout=1.
